// File: rtl/fifo_arb_pkg.sv
// Shared types and default sizing for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_GRANT = 1'b1
  } arb_state_e;

  localparam int DEF_BITS      = 32;
  localparam int DEF_NREQ      = 4;
  localparam int DEF_MAX_BURST = 4;

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Requester-to-FIFO write bundle; slave is the arbiter, master is the requester/FIFO side.
interface fifo_wr_arbiter_if
  import fifo_arb_pkg::*;
#(
  parameter int BITS = DEF_BITS,
  parameter int NREQ = DEF_NREQ
);

  logic [NREQ-1:0]           req_valid;
  logic [NREQ-1:0][BITS-1:0] req_data;
  logic [NREQ-1:0]           req_ready;
  logic                      fifo_wr_en;
  logic [BITS-1:0]           fifo_wr_data;
  logic                      fifo_wr_full;

  modport master (
    output req_valid, req_data, fifo_wr_full,
    input  req_ready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  req_valid, req_data, fifo_wr_full,
    output req_ready, fifo_wr_en, fifo_wr_data
  );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set bit of req after index last,
// wrapping, with last itself considered at lowest priority.
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] last,
  output logic                    found,
  output logic [$clog2(NREQ)-1:0] idx
);

  localparam int GW = $clog2(NREQ);

  logic [GW-1:0] cand [NREQ];

  // cand[k] is the requester k+1 positions after last
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_cand
    assign cand[gi] = GW'((int'(last) + gi + 1) % NREQ);
  end

  always_comb begin
    found = 1'b0;
    idx   = last;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter multiplexing NREQ requesters into one FIFO write port.
// Optional per-requester beat counters when FIFO_WR_ARBITER_STATS_EN is defined.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int BITS      = DEF_BITS,
  parameter int NREQ      = DEF_NREQ,
  parameter int MAX_BURST = DEF_MAX_BURST
) (
  input  logic                    wr_clk,
  input  logic                    wr_rst,
  fifo_wr_arbiter_if.slave        bus,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy
`ifdef FIFO_WR_ARBITER_STATS_EN
  ,
  output logic [NREQ-1:0][15:0]   beat_cnt
`endif
);

  localparam int GW = $clog2(NREQ);
  localparam int CW = $clog2(MAX_BURST + 1);

  arb_state_e    state_q, state_d;
  logic [GW-1:0] grant_q, grant_d;
  logic [GW-1:0] last_q, last_d;
  logic [CW-1:0] burst_q, burst_d;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          grant_valid;
  logic          can_xfer;
  logic          accept;
  logic          release_now;
  logic [NREQ-1:0] ready_vec;

  // last_q always equals grant_q while granted, so one picker serves both
  // the IDLE selection and the same-cycle re-arbitration on release.
  rr_pick #(.NREQ(NREQ)) u_pick (
    .req   (bus.req_valid),
    .last  (last_q),
    .found (pick_found),
    .idx   (pick_idx)
  );

  always_comb begin
    grant_valid = bus.req_valid[grant_q];
    can_xfer    = (state_q == ARB_GRANT) && !bus.fifo_wr_full;
    accept      = can_xfer && grant_valid;
    ready_vec   = '0;
    for (int i = 0; i < NREQ; i++) begin
      ready_vec[i] = can_xfer && (grant_q == GW'(i));
    end
  end

  assign bus.req_ready    = ready_vec;
  assign bus.fifo_wr_en   = accept;
  assign bus.fifo_wr_data = bus.req_data[grant_q];
  assign grant_id         = grant_q;
  assign busy             = (state_q == ARB_GRANT);

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    last_d      = last_q;
    burst_d     = burst_q;
    release_now = 1'b0;
    case (state_q)
      ARB_IDLE: begin
        if (pick_found) begin
          state_d = ARB_GRANT;
          grant_d = pick_idx;
          last_d  = pick_idx;
          burst_d = '0;
        end
      end
      ARB_GRANT: begin
        // a full FIFO freezes everything, including the burst position
        if (!bus.fifo_wr_full) begin
          if (!grant_valid) begin
            release_now = 1'b1;
          end else if (burst_q == CW'(MAX_BURST - 1)) begin
            release_now = 1'b1;
          end else begin
            burst_d = burst_q + CW'(1);
          end
          if (release_now) begin
            burst_d = '0;
            if (pick_found) begin
              grant_d = pick_idx;
              last_d  = pick_idx;
            end else begin
              state_d = ARB_IDLE;
            end
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge wr_clk or posedge wr_rst) begin
    if (wr_rst) begin
      state_q <= ARB_IDLE;
      grant_q <= '0;
      last_q  <= GW'(NREQ - 1);
      burst_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      burst_q <= burst_d;
    end
  end

`ifdef FIFO_WR_ARBITER_STATS_EN
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_stats
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
      cnt_d = cnt_q;
      if (accept && (grant_q == GW'(gi))) begin
        cnt_d = cnt_q + 16'd1;
      end
    end

    always_ff @(posedge wr_clk or posedge wr_rst) begin
      if (wr_rst) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end

    assign beat_cnt[gi] = cnt_q;
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with a write scoreboard of expected beats.
module tb_fifo_wr_arbiter;
  import fifo_arb_pkg::*;

  localparam int BITS = 32;
  localparam int NREQ = 4;
  localparam int MAXB = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.BITS(BITS), .NREQ(NREQ)) bus ();
  logic [1:0] grant_id;
  logic       busy;
`ifdef FIFO_WR_ARBITER_STATS_EN
  logic [NREQ-1:0][15:0] beat_cnt;
`endif

  fifo_wr_arbiter #(.BITS(BITS), .NREQ(NREQ), .MAX_BURST(MAXB)) dut (
    .wr_clk   (clk),
    .wr_rst   (rst),
    .bus      (bus),
    .grant_id (grant_id),
    .busy     (busy)
`ifdef FIFO_WR_ARBITER_STATS_EN
    ,
    .beat_cnt (beat_cnt)
`endif
  );

  typedef struct packed {
    logic [1:0]  id;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   src_cnt[NREQ];
  int   src_head[NREQ];
  int   exp_head[NREQ];
  logic [NREQ-1:0] mask;
  logic full_v;

  logic        obs_en, obs_busy;
  logic [1:0]  obs_gid;
  logic [3:0]  obs_ready;
  logic [31:0] obs_data;

  function automatic logic [31:0] beat(int i, int k);
    return {4'(i), 28'(k)};
  endfunction

  task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load(int i, int n);
    src_cnt[i] += n;
  endtask

  task automatic expect_beats(int i, int n);
    exp_t e;
    for (int k = 0; k < n; k++) begin
      e.id   = 2'(i);
      e.data = beat(i, exp_head[i]);
      exp_q.push_back(e);
      exp_head[i]++;
    end
  endtask

  task automatic drive();
    logic [NREQ-1:0]           v;
    logic [NREQ-1:0][BITS-1:0] d;
    for (int i = 0; i < NREQ; i++) begin
      v[i] = mask[i] && (src_cnt[i] > 0);
      d[i] = beat(i, src_head[i]);
    end
    bus.req_valid    = v;
    bus.req_data     = d;
    bus.fifo_wr_full = full_v;
  endtask

  task automatic flush();
    for (int i = 0; i < NREQ; i++) begin
      src_cnt[i]  = 0;
      exp_head[i] = src_head[i];
    end
    exp_q.delete();
  endtask

  // Observe one cycle at the falling edge, score any write, then advance.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    obs_en    = bus.fifo_wr_en;
    obs_busy  = busy;
    obs_gid   = grant_id;
    obs_ready = bus.req_ready;
    obs_data  = bus.fifo_wr_data;
    if (obs_en) begin
      if (exp_q.size() == 0) begin
        check("sb_unexpected_write", 64'(obs_data), 64'hDEAD);
      end else begin
        e = exp_q.pop_front();
        $display("write id=%0d data=%08h (expected id=%0d data=%08h)", obs_gid, obs_data, e.id, e.data);
        check("wr_id", 64'(obs_gid), 64'(e.id));
        check("wr_data", 64'(obs_data), 64'(e.data));
        check("wr_ready", 64'(obs_ready), 64'(1) << e.id);
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (bus.req_valid[i] && bus.req_ready[i]) begin
        src_head[i]++;
        src_cnt[i]--;
      end
    end
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic step(string tag, logic en, logic bsy, int gid);
    tick();
    check({tag, "_en"}, 64'(obs_en), 64'(en));
    check({tag, "_busy"}, 64'(obs_busy), 64'(bsy));
    if (gid >= 0) check({tag, "_gid"}, 64'(obs_gid), 64'(gid));
  endtask

  task automatic do_reset();
    rst    = 1'b1;
    full_v = 1'b0;
    mask   = '0;
    flush();
    drive();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      src_cnt[i]  = 0;
      src_head[i] = 0;
      exp_head[i] = 0;
    end
    // Reset values, with every requester asserting valid
    rst    = 1'b1;
    full_v = 1'b0;
    mask   = '1;
    for (int i = 0; i < NREQ; i++) load(i, 2);
    drive();
    @(negedge clk);
    check("rst_en", 64'(bus.fifo_wr_en), 64'(0));
    check("rst_ready", 64'(bus.req_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_gid", 64'(grant_id), 64'(0));
    do_reset();

    // Single requester, 6 beats: bubble, burst of 4, bubble-free re-grant, 2 more
    mask = 4'b0001;
    load(0, 6);
    expect_beats(0, 6);
    drive();
    step("s1_bubble", 1'b0, 1'b0, -1);
    for (int b = 0; b < 6; b++) step("s1_beat", 1'b1, 1'b1, 0);
    step("s1_release", 1'b0, 1'b1, -1);
    step("s1_idle", 1'b0, 1'b0, -1);
    check("s1_drain", 64'(exp_q.size()), 64'(0));

    // All four valid: grants 0,1,2,3,0 of exactly 4 beats, back to back
    do_reset();
    mask = 4'b1111;
    load(0, 8);
    for (int i = 1; i < NREQ; i++) load(i, 4);
    for (int i = 0; i < NREQ; i++) expect_beats(i, 4);
    expect_beats(0, 4);
    drive();
    step("s2_bubble", 1'b0, 1'b0, -1);
    for (int g = 0; g < 5; g++) begin
      for (int b = 0; b < MAXB; b++) step("s2_beat", 1'b1, 1'b1, g % NREQ);
    end
    step("s2_release", 1'b0, 1'b1, -1);
    step("s2_idle", 1'b0, 1'b0, -1);
    check("s2_drain", 64'(exp_q.size()), 64'(0));

    // FIFO full for 3 cycles after beat 2; burst position must survive the stall
    mask = 4'b1010;
    load(1, 6);
    load(3, 1);
    expect_beats(1, 4);
    expect_beats(3, 1);
    expect_beats(1, 2);
    drive();
    step("s3_bubble", 1'b0, 1'b0, -1);
    step("s3_beat1", 1'b1, 1'b1, 1);
    step("s3_beat2", 1'b1, 1'b1, 1);
    full_v = 1'b1;
    drive();
    for (int c = 0; c < 3; c++) begin
      step("s3_full", 1'b0, 1'b1, 1);
      check("s3_full_ready", 64'(obs_ready), 64'(0));
    end
    full_v = 1'b0;
    drive();
    step("s3_beat3", 1'b1, 1'b1, 1);
    step("s3_beat4", 1'b1, 1'b1, 1);
    step("s3_next", 1'b1, 1'b1, 3);
    step("s3_drop3", 1'b0, 1'b1, 3);
    step("s3_tail", 1'b1, 1'b1, 1);
    step("s3_tail", 1'b1, 1'b1, 1);
    step("s3_release", 1'b0, 1'b1, -1);
    step("s3_idle", 1'b0, 1'b0, -1);
    check("s3_drain", 64'(exp_q.size()), 64'(0));

    // Requester 2 drops valid after one beat while 3 is waiting
    do_reset();
    mask = 4'b1100;
    load(2, 1);
    load(3, 2);
    expect_beats(2, 1);
    expect_beats(3, 2);
    drive();
    step("s4_bubble", 1'b0, 1'b0, -1);
    step("s4_beat2", 1'b1, 1'b1, 2);
    step("s4_drop", 1'b0, 1'b1, 2);
    step("s4_beat3", 1'b1, 1'b1, 3);
    step("s4_beat3", 1'b1, 1'b1, 3);
    step("s4_release", 1'b0, 1'b1, -1);
    step("s4_idle", 1'b0, 1'b0, -1);
    check("s4_drain", 64'(exp_q.size()), 64'(0));

    // Reset in the middle of a burst, then requester 0 must win first
    mask = 4'b0100;
    load(2, 6);
    expect_beats(2, 2);
    drive();
    step("s5_bubble", 1'b0, 1'b0, -1);
    step("s5_beat", 1'b1, 1'b1, 2);
    step("s5_beat", 1'b1, 1'b1, 2);
    rst = 1'b1;
    #1;
    check("s5_rst_en", 64'(bus.fifo_wr_en), 64'(0));
    check("s5_rst_ready", 64'(bus.req_ready), 64'(0));
    check("s5_rst_busy", 64'(busy), 64'(0));
    check("s5_rst_gid", 64'(grant_id), 64'(0));
    check("s5_drain", 64'(exp_q.size()), 64'(0));
    flush();
    @(posedge clk);
    #1;
    rst  = 1'b0;
    mask = 4'b0101;
    load(0, 1);
    load(2, 1);
    expect_beats(0, 1);
    expect_beats(2, 1);
    drive();
    step("s5_bubble2", 1'b0, 1'b0, -1);
    step("s5_first", 1'b1, 1'b1, 0);
    step("s5_drop0", 1'b0, 1'b1, 0);
    step("s5_second", 1'b1, 1'b1, 2);
    step("s5_release", 1'b0, 1'b1, -1);
    step("s5_idle", 1'b0, 1'b0, -1);
    check("s5_drain2", 64'(exp_q.size()), 64'(0));

`ifdef FIFO_WR_ARBITER_STATS_EN
    // Twenty back-to-back grants: five bursts per requester
    do_reset();
    mask = 4'b1111;
    for (int i = 0; i < NREQ; i++) load(i, 20);
    for (int r = 0; r < 5; r++) begin
      for (int i = 0; i < NREQ; i++) expect_beats(i, 4);
    end
    drive();
    step("st_bubble", 1'b0, 1'b0, -1);
    for (int g = 0; g < 20; g++) begin
      for (int b = 0; b < MAXB; b++) step("st_beat", 1'b1, 1'b1, g % NREQ);
    end
    step("st_release", 1'b0, 1'b1, -1);
    step("st_idle", 1'b0, 1'b0, -1);
    check("st_drain", 64'(exp_q.size()), 64'(0));
    for (int i = 0; i < NREQ; i++) check("st_beat_cnt", 64'(beat_cnt[i]), 64'(20));
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
